// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator with byte valid/ready streaming and frame-controlled chip select.
// Optional build macro SPI_MASTER_LSB_FIRST_EN shifts LSB first in both directions (default MSB first).
module spi_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       frame,
  output logic       busy
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_IDLE + 1);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
  // A byte accepted straight after the last fall already spent one low cycle in WAIT.
  localparam logic [DW-1:0] DIV_FIRST = (CLK_DIV > 1) ? DW'(CLK_DIV - 2) : {DW{1'b0}};
  localparam logic [GW-1:0] GAP_LOAD  = GW'(CS_IDLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  function automatic logic [2:0] wire_idx(input logic [2:0] bit_pos);
`ifdef SPI_MASTER_LSB_FIRST_EN
    wire_idx = ~bit_pos;
`else
    wire_idx = bit_pos;
`endif
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic din);
`ifdef SPI_MASTER_LSB_FIRST_EN
    shift_in = {din, cur[7:1]};
`else
    shift_in = {cur[6:0], din};
`endif
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic            spi_clk_r;
  logic            spi_cs_r;
  logic            spi_mosi_r;
  logic [7:0]      tx_byte_r;
  logic [7:0]      rx_shift_r;
  logic [7:0]      rx_data_r;
  logic            rx_valid_r;
  logic [DW-1:0]   div_r;
  logic [2:0]      bit_r;
  logic [GW-1:0]   gap_r;
  logic            tx_ready_s;
  logic            busy_s;
  logic            accept_s;
  logic            tick_s;
  logic            last_fall_s;

  assign accept_s    = tx_valid && tx_ready_s;
  assign tick_s      = (div_r == {DW{1'b0}});
  assign last_fall_s = (state_r == ST_SHIFT) && tick_s && spi_clk_r && (bit_r == 3'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a pending byte in WAIT wins over a dropped frame.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = accept_s ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_s = last_fall_s ? ST_WAIT : ST_SHIFT;
      ST_WAIT: begin
        if (tx_valid) begin
          state_s = ST_SHIFT;
        end else if (!frame) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_GAP:   state_s = (gap_r == {GW{1'b0}}) ? ST_IDLE : ST_GAP;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    tx_ready_s = 1'b0;
    busy_s     = 1'b1;
    case (state_r)
      ST_IDLE:  begin tx_ready_s = 1'b1; busy_s = 1'b0; end
      ST_WAIT:  begin tx_ready_s = 1'b1; busy_s = 1'b1; end
      ST_SHIFT: begin tx_ready_s = 1'b0; busy_s = 1'b1; end
      ST_GAP:   begin tx_ready_s = 1'b0; busy_s = 1'b1; end
      default:  begin tx_ready_s = 1'b0; busy_s = 1'b1; end
    endcase
  end

  // Serial datapath: divider, bit counter, shift registers and CS gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_clk_r  <= 1'b0;
      spi_cs_r   <= 1'b1;
      spi_mosi_r <= 1'b0;
      tx_byte_r  <= 8'h00;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      div_r      <= {DW{1'b0}};
      bit_r      <= 3'd0;
      gap_r      <= {GW{1'b0}};
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_WAIT: begin
          if (accept_s) begin
            spi_cs_r   <= 1'b0;
            tx_byte_r  <= tx_data;
            spi_mosi_r <= tx_data[wire_idx(3'd7)];
            bit_r      <= 3'd7;
            div_r      <= ((state_r == ST_WAIT) && rx_valid_r) ? DIV_FIRST : DIV_LOAD;
          end else if ((state_r == ST_WAIT) && !frame) begin
            spi_cs_r <= 1'b1;
            gap_r    <= GAP_LOAD;
          end
        end
        ST_SHIFT: begin
          if (tick_s) begin
            spi_clk_r <= ~spi_clk_r;
            div_r     <= DIV_LOAD;
            if (!spi_clk_r) begin
              rx_shift_r <= shift_in(rx_shift_r, spi_miso);
            end else if (bit_r == 3'd0) begin
              rx_data_r  <= rx_shift_r;
              rx_valid_r <= 1'b1;
            end else begin
              bit_r      <= bit_r - 3'd1;
              spi_mosi_r <= tx_byte_r[wire_idx(bit_r - 3'd1)];
            end
          end else begin
            div_r <= div_r - DW'(1);
          end
        end
        ST_GAP: begin
          if (gap_r != {GW{1'b0}}) begin
            gap_r <= gap_r - GW'(1);
          end
        end
        default: begin
          spi_cs_r <= 1'b1;
        end
      endcase
    end
  end

  assign spi_clk  = spi_clk_r;
  assign spi_cs   = spi_cs_r;
  assign spi_mosi = spi_mosi_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign tx_ready = tx_ready_s;
  assign busy     = busy_s;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (CLK_DIV=2/CS_IDLE=2 and CLK_DIV=1/CS_IDLE=3)
// sharing one mode-0 responder model that shifts out on spi_clk fall and captures on rise.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       a_valid, b_valid, frame;
  logic       a_clk, a_cs, a_mosi, a_ready, a_rxv, a_busy;
  logic       b_clk, b_cs, b_mosi, b_ready, b_rxv, b_busy;
  logic [7:0] a_rx, b_rx;
  logic       miso, sel;
  logic       m_clk, m_cs, m_mosi;
  logic [7:0] resp_mem [16];
  logic [2:0] m_pos, cap_n;
  logic [3:0] m_byte;
  logic [7:0] cap_sh, cur_wire;
  logic [7:0] cap_q [$];
  int         pass_cnt = 0;
  int         chk_cnt  = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(2), .CS_IDLE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .spi_clk(a_clk), .spi_cs(a_cs), .spi_mosi(a_mosi),
    .spi_miso(miso), .tx_data(tx_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .rx_data(a_rx), .rx_valid(a_rxv), .frame(frame), .busy(a_busy));

  spi_master #(.CLK_DIV(1), .CS_IDLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .spi_clk(b_clk), .spi_cs(b_cs), .spi_mosi(b_mosi),
    .spi_miso(miso), .tx_data(tx_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .rx_data(b_rx), .rx_valid(b_rxv), .frame(frame), .busy(b_busy));

  function automatic logic [7:0] wire_order(input logic [7:0] b);
    logic [7:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  assign m_clk  = sel ? b_clk  : a_clk;
  assign m_cs   = sel ? b_cs   : a_cs;
  assign m_mosi = sel ? b_mosi : a_mosi;

  always_comb begin
    cur_wire = wire_order(resp_mem[m_byte]);
    miso     = cur_wire[3'd7 - m_pos];
  end

  always @(negedge m_clk or posedge m_cs) begin
    if (m_cs) begin
      m_pos  <= 3'd0;
      m_byte <= 4'd0;
    end else if (m_pos == 3'd7) begin
      m_pos  <= 3'd0;
      m_byte <= m_byte + 4'd1;
    end else begin
      m_pos <= m_pos + 3'd1;
    end
  end

  always @(posedge m_clk or posedge m_cs) begin
    if (m_cs) begin
      cap_n <= 3'd0;
    end else begin
      cap_sh <= {cap_sh[6:0], m_mosi};
      cap_n  <= cap_n + 3'd1;
      if (cap_n == 3'd7) cap_q.push_back(wire_order({cap_sh[6:0], m_mosi}));
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_cnt++; if (a_clk !== 1'b0) $display("FAIL rst_clk: got %b expected 0", a_clk); else pass_cnt++;
    chk_cnt++; if (a_cs !== 1'b1) $display("FAIL rst_cs: got %b expected 1", a_cs); else pass_cnt++;
    chk_cnt++; if (a_mosi !== 1'b0) $display("FAIL rst_mosi: got %b expected 0", a_mosi); else pass_cnt++;
    chk_cnt++; if (a_rx !== 8'h00) $display("FAIL rst_rx: got %h expected 00", a_rx); else pass_cnt++;
    chk_cnt++; if (a_rxv !== 1'b0) $display("FAIL rst_rxv: got %b expected 0", a_rxv); else pass_cnt++;
    chk_cnt++; if (a_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", a_busy); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", a_ready); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_single(input logic [7:0] tx, input logic [7:0] resp, input string tag);
    logic [7:0] mo, exp_w;
    int nb, rxv_bad, base;
    logic prev;
    resp_mem[0] = resp;
    base = cap_q.size();
    exp_w = wire_order(tx);
    frame = 1'b0;
    mo = 8'h00; nb = 0; rxv_bad = 0; prev = 1'b0;
    @(negedge clk);
    chk_cnt++; if (a_ready !== 1'b1 || a_cs !== 1'b1) $display("FAIL %s_idle: got ready=%b cs=%b expected 1 1", tag, a_ready, a_cs); else pass_cnt++;
    tx_data = tx; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; tx_data = ~tx;
    chk_cnt++; if (a_cs !== 1'b0 || a_ready !== 1'b0) $display("FAIL %s_start: got cs=%b ready=%b expected 0 0", tag, a_cs, a_ready); else pass_cnt++;
    chk_cnt++; if (a_mosi !== exp_w[7]) $display("FAIL %s_first_bit: got %b expected %b", tag, a_mosi, exp_w[7]); else pass_cnt++;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (a_clk && !prev) begin mo = {mo[6:0], a_mosi}; nb++; end
      prev = a_clk;
      if (a_rxv !== (k == 32)) rxv_bad++;
      if (k == 32) begin
        chk_cnt++; if (a_rx !== resp) $display("FAIL %s_rx: got %h expected %h", tag, a_rx, resp); else pass_cnt++;
        chk_cnt++; if (a_clk !== 1'b0 || a_cs !== 1'b0) $display("FAIL %s_wait: got clk=%b cs=%b expected 0 0", tag, a_clk, a_cs); else pass_cnt++;
      end
      if (k == 33) begin
        chk_cnt++; if (a_cs !== 1'b1 || a_busy !== 1'b1 || a_ready !== 1'b0) $display("FAIL %s_gap: got cs=%b busy=%b ready=%b expected 1 1 0", tag, a_cs, a_busy, a_ready); else pass_cnt++;
      end
      if (k == 34) begin
        chk_cnt++; if (a_ready !== 1'b0 || a_busy !== 1'b1) $display("FAIL %s_gap2: got ready=%b busy=%b expected 0 1", tag, a_ready, a_busy); else pass_cnt++;
      end
      if (k == 35) begin
        chk_cnt++; if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_cs !== 1'b1) $display("FAIL %s_end: got ready=%b busy=%b cs=%b expected 1 0 1", tag, a_ready, a_busy, a_cs); else pass_cnt++;
      end
    end
    chk_cnt++; if (nb != 8 || mo !== exp_w) $display("FAIL %s_mosi: got %0d bits %h expected 8 bits %h", tag, nb, mo, exp_w); else pass_cnt++;
    chk_cnt++; if (rxv_bad != 0) $display("FAIL %s_rxv_timing: got %0d bad cycles expected 0", tag, rxv_bad); else pass_cnt++;
    chk_cnt++; if (cap_q.size() != base + 1 || cap_q[base] !== tx) $display("FAIL %s_echo: got %0d bytes expected %h", tag, cap_q.size() - base, tx); else pass_cnt++;
  endtask

  task automatic test_burst();
    logic [7:0] b [8];
    int n, rxn, base, cs_bad, gap_bad, nrise, last_rise, last_rxv;
    logic acc, prev;
    for (int i = 0; i < 8; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      resp_mem[i] = (i == 0) ? 8'h3C : b[i-1];
    end
    base = cap_q.size();
    n = 0; rxn = 0; cs_bad = 0; gap_bad = 0; nrise = 0; last_rise = 0; last_rxv = 0; prev = 1'b0;
    frame = 1'b1;
    @(negedge clk);
    tx_data = b[0]; a_valid = 1'b1;
    acc = a_ready;
    for (int c = 0; c < 400 && rxn < 8; c++) begin
      @(negedge clk);
      if (acc) begin
        n++;
        if (n < 8) tx_data = b[n]; else a_valid = 1'b0;
      end
      if (a_cs !== 1'b0) cs_bad++;
      if (a_clk && !prev) begin
        if (nrise > 0 && c - last_rise != 4) gap_bad++;
        last_rise = c; nrise++;
      end
      prev = a_clk;
      if (a_rxv === 1'b1) begin
        if (rxn > 0) begin
          chk_cnt++; if (c - last_rxv != 32) $display("FAIL burst_spacing%0d: got %0d expected 32", rxn, c - last_rxv); else pass_cnt++;
        end
        chk_cnt++; if (a_rx !== resp_mem[rxn]) $display("FAIL burst_rx%0d: got %h expected %h", rxn, a_rx, resp_mem[rxn]); else pass_cnt++;
        last_rxv = c; rxn++;
      end
      acc = a_valid && a_ready;
    end
    chk_cnt++; if (rxn != 8) $display("FAIL burst_count: got %0d expected 8", rxn); else pass_cnt++;
    chk_cnt++; if (cs_bad != 0) $display("FAIL burst_cs: got %0d high cycles expected 0", cs_bad); else pass_cnt++;
    chk_cnt++; if (gap_bad != 0 || nrise != 64) $display("FAIL burst_clk: got %0d gaps %0d rises expected 0 64", gap_bad, nrise); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++; if (cap_q.size() <= base + i || cap_q[base+i] !== b[i]) $display("FAIL burst_echo%0d: got size %0d expected %h", i, cap_q.size() - base, b[i]); else pass_cnt++;
    end
    frame = 1'b0;
    for (int i = 0; i < 10 && !(a_ready && !a_busy); i++) @(negedge clk);
    chk_cnt++; if (a_ready !== 1'b1 || a_busy !== 1'b0) $display("FAIL burst_idle: got ready=%b busy=%b expected 1 0", a_ready, a_busy); else pass_cnt++;
  endtask

  task automatic test_held_frame();
    int hold_bad, cs_bad, rxv_at;
    logic got;
    resp_mem[0] = 8'h96; resp_mem[1] = 8'h0F;
    hold_bad = 0; cs_bad = 0; rxv_at = -1; got = 1'b0;
    frame = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (a_rxv === 1'b1) got = 1'b1;
    end
    chk_cnt++; if (!got || a_rx !== 8'h96) $display("FAIL held_rx0: got %h expected 96", a_rx); else pass_cnt++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_cs !== 1'b0 || a_clk !== 1'b0 || a_ready !== 1'b1) hold_bad++;
    end
    chk_cnt++; if (hold_bad != 0) $display("FAIL held_hold: got %0d bad cycles expected 0", hold_bad); else pass_cnt++;
    tx_data = 8'hFF; a_valid = 1'b1; frame = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) @(negedge clk);
      if (a_cs !== 1'b0) cs_bad++;
      if (a_rxv === 1'b1 && rxv_at < 0) rxv_at = k;
    end
    chk_cnt++; if (cs_bad != 0) $display("FAIL held_cs: got %0d high cycles expected 0", cs_bad); else pass_cnt++;
    chk_cnt++; if (rxv_at != 32) $display("FAIL held_rxv_at: got %0d expected 32", rxv_at); else pass_cnt++;
    chk_cnt++; if (a_rx !== 8'h0F) $display("FAIL held_rx1: got %h expected 0f", a_rx); else pass_cnt++;
    chk_cnt++; if (cap_q[$] !== 8'hFF) $display("FAIL held_echo: got %h expected ff", cap_q[$]); else pass_cnt++;
    for (int i = 0; i < 10 && !(a_ready && !a_busy); i++) @(negedge clk);
  endtask

  task automatic test_reset_mid_byte();
    int rxv_bad;
    rxv_bad = 0;
    resp_mem[0] = 8'h5A;
    frame = 1'b0;
    @(negedge clk);
    tx_data = 8'h53; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk_cnt++; if (a_clk !== 1'b1) $display("FAIL rmb_pre_clk: got %b expected 1", a_clk); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (a_cs !== 1'b1 || a_clk !== 1'b0 || a_mosi !== 1'b0) $display("FAIL rmb_outs: got cs=%b clk=%b mosi=%b expected 1 0 0", a_cs, a_clk, a_mosi); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b1 || a_busy !== 1'b0) $display("FAIL rmb_hs: got ready=%b busy=%b expected 1 0", a_ready, a_busy); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_rxv !== 1'b0 || a_cs !== 1'b1 || a_clk !== 1'b0) rxv_bad++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_rxv !== 1'b0) rxv_bad++;
    end
    chk_cnt++; if (rxv_bad != 0) $display("FAIL rmb_quiet: got %0d bad cycles expected 0", rxv_bad); else pass_cnt++;
    run_single(8'h53, 8'hA5, "rmb");
  endtask

  task automatic test_div1();
    int nrise, bad, last_rise, gapn, rxv_at, base;
    logic prev, done;
    sel = 1'b1;
    resp_mem[0] = 8'hC3;
    base = cap_q.size();
    nrise = 0; bad = 0; last_rise = 0; gapn = 0; rxv_at = -1; prev = 1'b0; done = 1'b0;
    frame = 1'b0;
    @(negedge clk);
    tx_data = 8'h00; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (b_clk && !prev) begin
        if (nrise > 0 && k - last_rise != 2) bad++;
        last_rise = k; nrise++;
      end
      prev = b_clk;
      if (b_rxv === 1'b1 && rxv_at < 0) rxv_at = k;
    end
    chk_cnt++; if (nrise != 8 || bad != 0) $display("FAIL div1_period: got %0d rises %0d bad expected 8 0", nrise, bad); else pass_cnt++;
    chk_cnt++; if (rxv_at != 16 || b_rx !== 8'hC3) $display("FAIL div1_byte0: got at %0d rx %h expected 16 c3", rxv_at, b_rx); else pass_cnt++;
    for (int k = 17; k < 40 && !done; k++) begin
      @(negedge clk);
      if (b_cs === 1'b1 && b_busy === 1'b1) gapn++;
      if (k == 17) begin tx_data = 8'hFF; b_valid = 1'b1; end
      if (b_cs === 1'b0) begin done = 1'b1; b_valid = 1'b0; end
    end
    chk_cnt++; if (!done || gapn != 3) $display("FAIL div1_cs_gap: got %0d cycles expected 3", gapn); else pass_cnt++;
    rxv_at = -1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (b_rxv === 1'b1 && rxv_at < 0) rxv_at = k;
    end
    chk_cnt++; if (rxv_at != 16 || b_rx !== 8'hC3) $display("FAIL div1_byte1: got at %0d rx %h expected 16 c3", rxv_at, b_rx); else pass_cnt++;
    chk_cnt++; if (cap_q.size() != base + 2 || cap_q[base] !== 8'h00 || cap_q[base+1] !== 8'hFF) $display("FAIL div1_echo: got %0d bytes expected 00 ff", cap_q.size() - base); else pass_cnt++;
    repeat (6) @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; frame = 1'b0; tx_data = 8'h00; sel = 1'b0;
    for (int i = 0; i < 16; i++) resp_mem[i] = 8'h00;
    test_reset();
    run_single(8'h53, 8'hA5, "single");
    test_burst();
    test_held_frame();
    test_reset_mid_byte();
    run_single(8'h01, 8'h80, "order");
    test_div1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
